// File: rtl/ecc_elgamal_seq_pkg.sv
// ecc_elgamal_seq_pkg: shared op codes, state encoding and point helpers for the ElGamal sequencer
package ecc_elgamal_seq_pkg;
  localparam logic OP_DBL = 1'b0;
  localparam logic OP_ADD = 1'b1;
  // helpers take coordinates zero-extended to NMAX, so field widths up to NMAX are supported
  localparam int NMAX = 64;
  typedef enum logic [2:0] {IDLE, SCAN, MDBL, MADD, WAIT, FADD, FIN} state_e;
  function automatic logic pt_is_inf(input logic [NMAX-1:0] z);
    return z == '0;
  endfunction
  function automatic logic [NMAX-1:0] pt_neg_y(input logic [NMAX-1:0] x, input logic [NMAX-1:0] y);
    return x ^ y;
  endfunction
endpackage

// File: rtl/ecc_elgamal_seq_if.sv
// ecc_elgamal_seq_if: request/ack bus between the sequencer and the external point unit
interface ecc_elgamal_seq_if #(parameter int N = 3);
  logic           op_req;
  logic           op_code;
  logic [3*N-1:0] op_a;
  logic [3*N-1:0] op_b;
  logic           op_ack;
  logic [3*N-1:0] op_res;
  modport master (output op_req, op_code, op_a, op_b, input op_ack, op_res);
  modport slave (input op_req, op_code, op_a, op_b, output op_ack, op_res);
endinterface

// File: rtl/ecc_elgamal_seq_mult.sv
// ecc_scalar_mult: left-to-right double-and-add over an external point unit, or a single ADD(a_i, b_i)
module ecc_scalar_mult
  import ecc_elgamal_seq_pkg::*;
#(
  parameter int N   = 3,
  parameter int K   = 3,
  parameter int TMO = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   go_i,
  input  logic                   single_i,
  input  logic [K-1:0]           scalar_i,
  input  logic [3*N-1:0]         a_i,
  input  logic [3*N-1:0]         b_i,
  output logic                   done_o,
  output logic                   err_o,
  output logic [3*N-1:0]         res_o,
  ecc_elgamal_seq_if.master      op
);
  localparam int CW = $clog2(K + 1);
  localparam int WW = $clog2(TMO + 1);
  localparam logic [3*N-1:0] PT_INF = {{N{1'b0}}, N'(1), {N{1'b0}}};
  state_e st_q, st_d;
  logic [K-1:0] sc_q, sc_d;
  logic [CW-1:0] n_q, n_d;
  logic [WW-1:0] w_q, w_d;
  logic [3*N-1:0] acc_q, acc_d, base_q, base_d, opa_q, opa_d, opb_q, opb_d;
  logic req_q, req_d, code_q, code_d, done_q, done_d, err_q, err_d;
  assign op.op_req  = req_q;
  assign op.op_code = code_q;
  assign op.op_a    = opa_q;
  assign op.op_b    = opb_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign res_o      = acc_q;
  // n_q counts leading zeros while scanning, then holds the scalar bits still to process
  always_comb begin
    st_d   = st_q;
    sc_d   = sc_q;
    n_d    = n_q;
    w_d    = w_q;
    acc_d  = acc_q;
    base_d = base_q;
    opa_d  = opa_q;
    opb_d  = opb_q;
    req_d  = req_q;
    code_d = code_q;
    done_d = 1'b0;
    err_d  = err_q;
    case (st_q)
      IDLE: if (go_i) begin
        acc_d  = a_i;
        base_d = single_i ? b_i : a_i;
        sc_d   = scalar_i;
        n_d    = single_i ? CW'(1) : '0;
        err_d  = 1'b0;
        st_d   = single_i ? MADD : SCAN;
      end
      SCAN: begin
        sc_d = sc_q << 1;
        if (sc_q[K-1]) begin
          acc_d  = base_q;
          n_d    = CW'(K - 1) - n_q;
          done_d = n_q == CW'(K - 1);
          st_d   = done_d ? IDLE : MDBL;
        end else begin
          n_d = n_q + CW'(1);
          if (n_q == CW'(K - 1)) begin
            acc_d  = PT_INF;
            done_d = 1'b1;
            st_d   = IDLE;
          end
        end
      end
      MDBL, MADD: begin
        req_d  = 1'b1;
        w_d    = '0;
        code_d = (st_q == MADD) ? OP_ADD : OP_DBL;
        opa_d  = acc_q;
        opb_d  = base_q;
        st_d   = WAIT;
      end
      WAIT: if (op.op_ack) begin
        req_d = 1'b0;
        acc_d = op.op_res;
        if (code_q == OP_DBL && sc_q[K-1]) st_d = MADD;
        else begin
          sc_d   = sc_q << 1;
          n_d    = n_q - CW'(1);
          done_d = n_q == CW'(1);
          st_d   = done_d ? IDLE : MDBL;
        end
      end else if (w_q == WW'(TMO - 1)) begin
        req_d  = 1'b0;
        err_d  = 1'b1;
        done_d = 1'b1;
        st_d   = IDLE;
      end else w_d = w_q + WW'(1);
      default: st_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st_q   <= IDLE;
      sc_q   <= '0;
      n_q    <= '0;
      w_q    <= '0;
      acc_q  <= '0;
      base_q <= '0;
      opa_q  <= '0;
      opb_q  <= '0;
      req_q  <= 1'b0;
      code_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      sc_q   <= sc_d;
      n_q    <= n_d;
      w_q    <= w_d;
      acc_q  <= acc_d;
      base_q <= base_d;
      opa_q  <= opa_d;
      opb_q  <= opb_d;
      req_q  <= req_d;
      code_q <= code_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
endmodule

// File: rtl/ecc_elgamal_seq.sv
// ecc_elgamal_seq: ElGamal encrypt/decrypt sequencer driving one reused scalar multiplier
module ecc_elgamal_seq
  import ecc_elgamal_seq_pkg::*;
#(
  parameter int N   = 3,
  parameter int K   = 3,
  parameter int TMO = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic [K-1:0]      scalar_i,
  input  logic [3*N-1:0]    a_pt_i,
  input  logic [3*N-1:0]    b_pt_i,
  input  logic [3*N-1:0]    msg_pt_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [3*N-1:0]    out1_pt_o,
  output logic [3*N-1:0]    out2_pt_o,
  ecc_elgamal_seq_if.master op
);
  state_e st_q, st_d;
  logic mode_q, mode_d, pass_q, pass_d, busy_q, busy_d, err_q, err_d;
  logic [K-1:0] scalar_q, scalar_d;
  logic [3*N-1:0] b_q, b_d, msg_q, msg_d, c1_q, c1_d, s_q, s_d, out1_q, out1_d, out2_q, out2_d;
  logic sm_go, sm_done, sm_err;
  logic [K-1:0] sm_scalar;
  logic [3*N-1:0] sm_a, sm_res, res_neg;
  logic s_inf, msg_inf;
  ecc_scalar_mult #(.N(N), .K(K), .TMO(TMO)) u_mult (
    .clk, .rst_n, .go_i(sm_go), .single_i(st_q == FADD), .scalar_i(sm_scalar),
    .a_i(sm_a), .b_i(s_q), .done_o(sm_done), .err_o(sm_err), .res_o(sm_res), .op(op)
  );
  assign res_neg   = {sm_res[3*N-1:2*N],
                      N'(pt_neg_y(NMAX'(sm_res[3*N-1:2*N]), NMAX'(sm_res[2*N-1:N]))),
                      sm_res[N-1:0]};
  assign s_inf     = pt_is_inf(NMAX'(s_q[N-1:0]));
  assign msg_inf   = pt_is_inf(NMAX'(msg_q[N-1:0]));
  assign busy_o    = busy_q;
  assign done_o    = st_q == FIN;
  assign err_o     = err_q;
  assign out1_pt_o = out1_q;
  assign out2_pt_o = out2_q;
  always_comb begin
    st_d      = st_q;
    mode_d    = mode_q;
    pass_d    = pass_q;
    busy_d    = busy_q;
    err_d     = err_q;
    scalar_d  = scalar_q;
    b_d       = b_q;
    msg_d     = msg_q;
    c1_d      = c1_q;
    s_d       = s_q;
    out1_d    = out1_q;
    out2_d    = out2_q;
    sm_go     = 1'b0;
    sm_a      = (st_q == IDLE) ? a_pt_i : (st_q == FADD) ? msg_q : b_q;
    sm_scalar = (st_q == IDLE) ? scalar_i : scalar_q;
    case (st_q)
      IDLE: if (start_i) begin
        sm_go    = 1'b1;
        mode_d   = mode_i;
        scalar_d = scalar_i;
        b_d      = b_pt_i;
        msg_d    = msg_pt_i;
        pass_d   = 1'b0;
        busy_d   = 1'b1;
        err_d    = 1'b0;
        c1_d     = '0;
        out1_d   = '0;
        out2_d   = '0;
        st_d     = SCAN;
      end
      // a zero scalar makes k*Q infinity too, so the second encrypt pass is skipped
      SCAN: if (sm_done) begin
        if (sm_err) begin
          busy_d = 1'b0;
          err_d  = 1'b1;
          st_d   = FIN;
        end else if (!mode_q && !pass_q && scalar_q != '0) begin
          sm_go  = 1'b1;
          c1_d   = sm_res;
          pass_d = 1'b1;
        end else begin
          c1_d = (mode_q || pass_q) ? c1_q : sm_res;
          s_d  = mode_q ? res_neg : sm_res;
          st_d = FADD;
        end
      end
      FADD: if (s_inf || msg_inf) begin
        out1_d = c1_q;
        out2_d = s_inf ? msg_q : s_q;
        busy_d = 1'b0;
        st_d   = FIN;
      end else begin
        sm_go = 1'b1;
        st_d  = WAIT;
      end
      WAIT: if (sm_done) begin
        err_d  = sm_err;
        out1_d = sm_err ? '0 : c1_q;
        out2_d = sm_err ? '0 : sm_res;
        busy_d = 1'b0;
        st_d   = FIN;
      end
      FIN: st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st_q     <= IDLE;
      mode_q   <= 1'b0;
      pass_q   <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      scalar_q <= '0;
      b_q      <= '0;
      msg_q    <= '0;
      c1_q     <= '0;
      s_q      <= '0;
      out1_q   <= '0;
      out2_q   <= '0;
    end else begin
      st_q     <= st_d;
      mode_q   <= mode_d;
      pass_q   <= pass_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      scalar_q <= scalar_d;
      b_q      <= b_d;
      msg_q    <= msg_d;
      c1_q     <= c1_d;
      s_q      <= s_d;
      out1_q   <= out1_d;
      out2_q   <= out2_d;
    end
endmodule
